// File: rtl/spi_packet_tx_slave_if.sv
// Pin- and packet-side signal bundle for spi_packet_tx_slave.
// The slave modport is the design's view; the master modport is the view of
// whatever drives it (MCU pins plus the packet assembler).
interface spi_packet_tx_slave_if #(
   parameter int PKT_BYTES = 32
);
   // SPI pins
   logic                   sck;
   logic                   sdi;
   logic                   sdo;
   logic                   load;
   logic                   done;
   // packet assembler side
   logic [PKT_BYTES*8-1:0] data_in;
   logic                   data_ready;
   logic                   data_ack;
   logic                   short_read;
   logic [7:0]             overrun_cnt;

   modport slave (
      input  sck, sdi, load, data_in, data_ready,
      output sdo, done, data_ack, short_read, overrun_cnt
   );

   modport master (
      output sck, sdi, load, data_in, data_ready,
      input  sdo, done, data_ack, short_read, overrun_cnt
   );
endinterface

// File: rtl/spi_packet_tx_slave.sv
// SPI mode-0 transmit-only slave streaming a sensor packet (plus optional
// mod-256 checksum byte) to the MCU using the LOAD/DONE handshake.
// Everything runs on clk: SCK, LOAD and SDI are synchronised and
// edge-detected, a shadow buffer takes the next packet while the current
// one shifts, and shadow overwrites are counted.
module spi_packet_tx_slave #(
   parameter int         PKT_BYTES   = 32,
   parameter int         APPEND_SUM  = 1,
   parameter int         MSB_FIRST   = 1,
   parameter logic [7:0] FILL_BYTE   = 8'h00,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   spi_packet_tx_slave_if.slave  bus
);

   localparam int PKT_W = PKT_BYTES * 8;
   localparam int TOTAL = (PKT_BYTES + APPEND_SUM) * 8;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ARMED,
      ST_SHIFT,
      ST_ACK
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sck_sync, load_sync, sdi_sync;
   logic                   sck_prev, load_prev;
   logic                   sck_s, load_s;
   logic                   sck_fall, load_fall, load_rise;
   logic                   unused_sdi;

   logic [PKT_W-1:0]       shadow_buf;
   logic                   shadow_valid;
   logic [7:0]             overrun_q;
   logic                   promote;

   logic [PKT_W-1:0]       active_buf;
   logic [7:0]             sum_q;

   logic [CNT_W-1:0]       bit_cnt, cnt_inc, sel_cnt;
   logic [2:0]             bit_pos, sel_pos, bit_idx;
   logic [CNT_W-4:0]       byte_idx;
   logic [7:0]             cur_byte;
   logic                   next_bit;
   logic                   sdo_q;

   logic                   done_c, data_ack_c, short_read_c;

   // mod-256 sum of all payload bytes of a packet
   function automatic logic [7:0] byte_sum(input logic [PKT_W-1:0] pkt);
      logic [7:0] s;
      s = 8'h00;
      for (int k = 0; k < PKT_BYTES; k++) s = s + pkt[8*k +: 8];
      return s;
   endfunction

   // Synchronise the asynchronous pins and keep one extra copy for edges.
   // NOTE: state is updated with <= so every flop samples pre-edge values;
   // a blocking = here would collapse the synchroniser chain into one stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync  <= '0;
         load_sync <= '1;
         sdi_sync  <= '0;
         sck_prev  <= 1'b0;
         load_prev <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
         load_sync <= {load_sync[SYNC_STAGES-2:0], bus.load};
         sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
         sck_prev  <= sck_s;
         load_prev <= load_s;
      end
   end

   assign sck_s     = sck_sync[SYNC_STAGES-1];
   assign load_s    = load_sync[SYNC_STAGES-1];
   assign sck_fall  = sck_prev & ~sck_s;
   assign load_fall = load_prev & ~load_s;
   assign load_rise = ~load_prev & load_s;
   // MOSI is synchronised for pin compatibility only; nothing consumes it.
   assign unused_sdi = ^sdi_sync;

   assign promote = (state_q == ST_EMPTY) && shadow_valid;

   // Shadow valid flag and saturating overrun counter. A capture in the same
   // cycle as a promotion refills the shadow and is not an overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_valid <= 1'b0;
         overrun_q    <= 8'h00;
      end else if (bus.data_ready) begin
         shadow_valid <= 1'b1;
         if (shadow_valid && !promote && overrun_q != 8'hFF)
            overrun_q <= overrun_q + 8'd1;
      end else if (promote) begin
         shadow_valid <= 1'b0;
      end
   end

   // Packet storage: shadow capture and promotion into the active buffer.
   // NOTE: these wide data registers are deliberately not reset; the valid
   // flag and FSM state guard every use, so reset would only cost routing.
   always_ff @(posedge clk) begin
      if (bus.data_ready) shadow_buf <= bus.data_in;
      if (promote) begin
         active_buf <= shadow_buf;
         sum_q      <= byte_sum(shadow_buf);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   // FSM next state and handshake outputs.
   // NOTE: every output gets a default before the case so no path leaves
   // a signal unassigned, which would infer a latch.
   always_comb begin
      state_d      = state_q;
      done_c       = 1'b0;
      data_ack_c   = 1'b0;
      short_read_c = 1'b0;
      case (state_q)
         ST_EMPTY: if (shadow_valid) state_d = ST_ARMED;
         ST_ARMED: begin
            done_c = 1'b1;
            if (load_fall) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            done_c = 1'b1;
            if (load_rise) state_d = ST_ACK;
         end
         ST_ACK: begin
            data_ack_c   = 1'b1;
            short_read_c = (bit_cnt < TOTAL_CNT);
            state_d      = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Select the bit that sdo must carry next: bit 0 while armed, the
   // following bit on each SCK fall while shifting; fill pattern past TOTAL.
   always_comb begin
      cnt_inc = (bit_cnt == TOTAL_CNT) ? bit_cnt : bit_cnt + CNT_W'(1);
      if (state_q == ST_SHIFT) begin
         sel_cnt = cnt_inc;
         sel_pos = bit_pos + 3'd1;
      end else begin
         sel_cnt = '0;
         sel_pos = 3'd0;
      end
      byte_idx = sel_cnt[CNT_W-1:3];
      cur_byte = FILL_BYTE;
      for (int k = 0; k < PKT_BYTES; k++)
         if (int'(byte_idx) == k) cur_byte = active_buf[8*k +: 8];
      if (APPEND_SUM != 0 && int'(byte_idx) == PKT_BYTES) cur_byte = sum_q;
      bit_idx  = (MSB_FIRST != 0) ? ~sel_pos : sel_pos;
      next_bit = cur_byte[bit_idx];
   end

   // Bit counter, position within byte and registered MISO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         bit_pos <= 3'd0;
         sdo_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_ARMED: begin
               bit_cnt <= '0;
               bit_pos <= 3'd0;
               sdo_q   <= next_bit;
            end
            ST_SHIFT: begin
               if (sck_fall) begin
                  bit_cnt <= cnt_inc;
                  bit_pos <= bit_pos + 3'd1;
                  sdo_q   <= next_bit;
               end
            end
            default: sdo_q <= 1'b0;
         endcase
      end
   end

   assign bus.sdo         = sdo_q;
   assign bus.done        = done_c;
   assign bus.data_ack    = data_ack_c;
   assign bus.short_read  = short_read_c;
   assign bus.overrun_cnt = overrun_q;

endmodule

// File: tb/tb_spi_packet_tx_slave.sv
// Directed bench for spi_packet_tx_slave: a 4-byte MSB-first instance with
// checksum and a 1-byte LSB-first instance with a non-zero fill pattern.
module tb_spi_packet_tx_slave;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   spi_packet_tx_slave_if #(.PKT_BYTES(4)) bus ();
   spi_packet_tx_slave_if #(.PKT_BYTES(1)) lbus ();

   spi_packet_tx_slave #(
      .PKT_BYTES(4), .APPEND_SUM(1), .MSB_FIRST(1),
      .FILL_BYTE(8'h00), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   spi_packet_tx_slave #(
      .PKT_BYTES(1), .APPEND_SUM(1), .MSB_FIRST(0),
      .FILL_BYTE(8'hA5), .SYNC_STAGES(3)
   ) dut_lsb (
      .clk(clk), .rst_n(rst_n), .bus(lbus)
   );

   task automatic idle_pins();
      bus.sck = 1'b0;  bus.sdi = 1'b0;  bus.load = 1'b1;
      bus.data_in = '0;  bus.data_ready = 1'b0;
      lbus.sck = 1'b0; lbus.sdi = 1'b0; lbus.load = 1'b1;
      lbus.data_in = '0; lbus.data_ready = 1'b0;
   endtask

   task automatic push(input logic [31:0] pkt);
      @(negedge clk);
      bus.data_in    = pkt;
      bus.data_ready = 1'b1;
      @(negedge clk);
      bus.data_ready = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cyc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) ok = 1'b1;
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: done never rose within %0d cycles", name, max_cyc);
      end
   endtask

   // Mode-0 master: sample sdo at each SCK rise, then drop SCK.
   task automatic spi_read(input int nbits, output logic [63:0] bits);
      bits = '0;
      for (int i = 0; i < nbits; i++) begin
         repeat (5) @(negedge clk);
         bits = {bits[62:0], bus.sdo};
         bus.sck = 1'b1;
         repeat (5) @(negedge clk);
         bus.sck = 1'b0;
      end
   endtask

   task automatic start_transfer();
      bus.load = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic end_transfer(output int acks, output int shorts);
      acks = 0; shorts = 0;
      bus.load = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.data_ack === 1'b1)   acks++;
         if (bus.short_read === 1'b1) shorts++;
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
      n_checks++;
      if (bus.sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b want 0", bus.sdo); end
      n_checks++;
      if (bus.data_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.data_ack); end
      n_checks++;
      if (bus.short_read !== 1'b0) begin n_fail++; $display("FAIL reset_short: got %b want 0", bus.short_read); end
      n_checks++;
      if (bus.overrun_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_overrun: got %h want 00", bus.overrun_cnt); end
      n_checks++;
      if (lbus.done !== 1'b0) begin n_fail++; $display("FAIL reset_lsb_done: got %b want 0", lbus.done); end
   endtask

   // Bytes 11 22 33 44, checksum AA, then fill 00.
   task automatic test_full_packet();
      logic [63:0] rx;
      logic [7:0]  exp_bytes [6];
      int acks, shorts;
      exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'h00};
      push(32'h4433_2211);
      wait_done("full_arm", 20);
      start_transfer();
      spi_read(48, rx);
      for (int b = 0; b < 6; b++) begin
         n_checks++;
         if (rx[47-8*b -: 8] !== exp_bytes[b]) begin
            n_fail++;
            $display("FAIL full_byte%0d: got %h want %h", b, rx[47-8*b -: 8], exp_bytes[b]);
         end
      end
      end_transfer(acks, shorts);
      n_checks++;
      if (acks != 1) begin n_fail++; $display("FAIL full_ack: got %0d pulses want 1", acks); end
      n_checks++;
      if (shorts != 0) begin n_fail++; $display("FAIL full_short: got %0d pulses want 0", shorts); end
      n_checks++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL full_done_after: got %b want 0", bus.done); end
   endtask

   // Ack after 12 bits; a packet queued in the shadow arms afterwards.
   task automatic test_short_read();
      logic [63:0] rx;
      int acks, shorts, low;
      bit rose;
      push(32'h0D0C_0B0A);
      wait_done("short_arm", 20);
      start_transfer();
      spi_read(12, rx);
      n_checks++;
      if (rx[11:0] !== 12'h0A0) begin n_fail++; $display("FAIL short_bits: got %h want 0a0", rx[11:0]); end
      push(32'h0000_0081);
      bus.load = 1'b1;
      acks = 0; shorts = 0; low = 0; rose = 1'b0;
      for (int i = 0; i < 30 && !rose; i++) begin
         @(negedge clk);
         if (bus.data_ack === 1'b1)   acks++;
         if (bus.short_read === 1'b1) shorts++;
         if (acks > 0) begin
            if (bus.done === 1'b1) rose = 1'b1;
            else                   low++;
         end
      end
      n_checks++;
      if (acks != 1) begin n_fail++; $display("FAIL short_ack: got %0d pulses want 1", acks); end
      n_checks++;
      if (shorts != 1) begin n_fail++; $display("FAIL short_flag: got %0d pulses want 1", shorts); end
      n_checks++;
      if (!rose || low < 2) begin
         n_fail++;
         $display("FAIL short_gap: rose=%0d done-low cycles=%0d want rose=1 low>=2", rose, low);
      end
      start_transfer();
      spi_read(8, rx);
      n_checks++;
      if (rx[7:0] !== 8'h81) begin n_fail++; $display("FAIL short_next_byte0: got %h want 81", rx[7:0]); end
      end_transfer(acks, shorts);
   endtask

   // A fills the empty shadow, B and C overwrite it: two overruns, C wins.
   task automatic test_overrun();
      logic [63:0] rx;
      int acks, shorts;
      push(32'h5555_5555);
      wait_done("ovr_arm", 20);
      start_transfer();
      spi_read(4, rx);
      push(32'h0000_00A1);
      spi_read(2, rx);
      push(32'h0000_00B2);
      push(32'h0000_00C3);
      n_checks++;
      if (bus.overrun_cnt !== 8'd2) begin n_fail++; $display("FAIL ovr_count: got %0d want 2", bus.overrun_cnt); end
      spi_read(3, rx);
      end_transfer(acks, shorts);
      n_checks++;
      if (acks != 1) begin n_fail++; $display("FAIL ovr_ack: got %0d pulses want 1", acks); end
      n_checks++;
      if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ovr_rearm: got done=%b want 1", bus.done); end
      start_transfer();
      spi_read(8, rx);
      n_checks++;
      if (rx[7:0] !== 8'hC3) begin n_fail++; $display("FAIL ovr_latest: got %h want c3", rx[7:0]); end
      end_transfer(acks, shorts);
      n_checks++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL ovr_shadow_empty: got done=%b want 0", bus.done); end
   endtask

   // Hold data_ready while armed: first cycle fills, the rest overwrite.
   task automatic test_overrun_saturate();
      push(32'h0000_00E7);
      wait_done("sat_arm", 20);
      @(negedge clk);
      bus.data_ready = 1'b1;
      repeat (100) @(negedge clk);
      bus.data_ready = 1'b0;
      n_checks++;
      if (bus.overrun_cnt !== 8'd101) begin n_fail++; $display("FAIL sat_mid: got %0d want 101", bus.overrun_cnt); end
      bus.data_ready = 1'b1;
      repeat (200) @(negedge clk);
      bus.data_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.overrun_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_max: got %0d want 255", bus.overrun_cnt); end
   endtask

   // Async reset after 17 SCKs of the armed packet: all cleared, no ack.
   task automatic test_reset_mid();
      logic [63:0] rx;
      int acks, shorts;
      start_transfer();
      spi_read(17, rx);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
      n_checks++;
      if (bus.sdo !== 1'b0) begin n_fail++; $display("FAIL rstmid_sdo: got %b want 0", bus.sdo); end
      n_checks++;
      if (bus.overrun_cnt !== 8'h00) begin n_fail++; $display("FAIL rstmid_overrun: got %0d want 0", bus.overrun_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      end_transfer(acks, shorts);
      n_checks++;
      if (acks != 0) begin n_fail++; $display("FAIL rstmid_no_ack: got %0d pulses want 0", acks); end
      n_checks++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard: got done=%b want 0", bus.done); end
   endtask

   // LOAD low before arming: SCK and LOAD rise ignored until a fresh fall.
   task automatic test_load_held();
      logic [63:0] rx;
      int acks, shorts;
      bus.load = 1'b0;
      repeat (6) @(negedge clk);
      push(32'h0000_0080);
      wait_done("held_arm", 20);
      repeat (4) @(negedge clk);
      n_checks++;
      if (bus.sdo !== 1'b1) begin n_fail++; $display("FAIL held_first_bit: got %b want 1", bus.sdo); end
      spi_read(3, rx);
      repeat (5) @(negedge clk);
      n_checks++;
      if (rx[2:0] !== 3'b111 || bus.sdo !== 1'b1) begin
         n_fail++;
         $display("FAIL held_no_shift: got bits=%b sdo=%b want 111/1", rx[2:0], bus.sdo);
      end
      end_transfer(acks, shorts);
      n_checks++;
      if (acks != 0 || bus.done !== 1'b1) begin
         n_fail++;
         $display("FAIL held_rise_ignored: got acks=%0d done=%b want 0/1", acks, bus.done);
      end
      start_transfer();
      spi_read(8, rx);
      n_checks++;
      if (rx[7:0] !== 8'h80) begin n_fail++; $display("FAIL held_byte0: got %h want 80", rx[7:0]); end
      end_transfer(acks, shorts);
      n_checks++;
      if (acks != 1 || shorts != 1) begin
         n_fail++;
         $display("FAIL held_ack: got acks=%0d shorts=%0d want 1/1", acks, shorts);
      end
   endtask

   // LSB-first: byte 01, sum 01, fill A5 -> 10000000 10000000 10100101.
   task automatic test_lsb_first();
      logic [23:0] rx;
      bit ok;
      int acks;
      @(negedge clk);
      lbus.data_in = 8'h01; lbus.data_ready = 1'b1;
      @(negedge clk);
      lbus.data_ready = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (lbus.done === 1'b1) ok = 1'b1;
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL lsb_arm: done never rose"); end
      lbus.load = 1'b0;
      repeat (8) @(negedge clk);
      rx = '0;
      for (int i = 0; i < 24; i++) begin
         repeat (5) @(negedge clk);
         rx = {rx[22:0], lbus.sdo};
         lbus.sck = 1'b1;
         repeat (5) @(negedge clk);
         lbus.sck = 1'b0;
      end
      n_checks++;
      if (rx[23:16] !== 8'b1000_0000) begin n_fail++; $display("FAIL lsb_byte0: got %b want 10000000", rx[23:16]); end
      n_checks++;
      if (rx[15:0] !== 16'b1000_0000_1010_0101) begin
         n_fail++;
         $display("FAIL lsb_sum_fill: got %b want 1000000010100101", rx[15:0]);
      end
      lbus.load = 1'b1;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (lbus.data_ack === 1'b1 && lbus.short_read === 1'b0) acks++;
      end
      n_checks++;
      if (acks != 1) begin n_fail++; $display("FAIL lsb_ack: got %0d clean pulses want 1", acks); end
   endtask

   initial begin
      idle_pins();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      test_full_packet();
      test_short_read();
      test_overrun();
      test_overrun_saturate();
      test_reset_mid();
      test_load_held();
      test_lsb_first();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
